// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops, iterative one-bit-per-cycle
// shifts and a shift-and-add unsigned multiplier, with a {C,L,F,Z,N} flag register.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic             imm_sel,
    input  logic [WIDTH-1:0] rdest,
    input  logic [WIDTH-1:0] rsrc,
    input  logic [7:0]       imm,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic [4:0]       flags
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_ADDU  = 5'b00010;
    localparam logic [4:0] OP_ADDC  = 5'b00100;
    localparam logic [4:0] OP_ADDCU = 5'b00101;
    localparam logic [4:0] OP_SUB   = 5'b01000;
    localparam logic [4:0] OP_CMP   = 5'b01010;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_NOT   = 5'b10000;
    localparam logic [4:0] OP_LSH   = 5'b10001;
    localparam logic [4:0] OP_RSH   = 5'b10011;
    localparam logic [4:0] OP_ARSH  = 5'b10110;
    localparam logic [4:0] OP_MUL   = 5'b11000;

    localparam int FC = 4;
    localparam int FL = 3;
    localparam int FF = 2;
    localparam int FZ = 1;
    localparam int FN = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0] lo_r, lo_s;
    logic [WIDTH-1:0] mcand_r, mcand_s;
    logic [4:0]       op_r, op_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic [4:0]       flags_r, flags_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;

    logic [WIDTH-1:0]   b_s;
    logic [WIDTH-1:0]   logic_res_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic               cin_s;
    logic               add_ovf_s;
    logic               sub_ovf_s;
    logic               lt_s;
    logic               slt_s;
    logic [SHW-1:0]     n_s;
    logic [WIDTH-1:0]   sh_first_s;
    logic [WIDTH-1:0]   sh_next_s;
    logic [2*WIDTH-1:0] mul_first_s;
    logic [2*WIDTH-1:0] mul_next_s;

    function automatic logic [WIDTH-1:0] shift_one(input logic [4:0] op, input logic [WIDTH-1:0] v);
        case (op)
            OP_LSH:  shift_one = {v[WIDTH-2:0], 1'b0};
            OP_RSH:  shift_one = {1'b0, v[WIDTH-1:1]};
            OP_ARSH: shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
            default: shift_one = v;
        endcase
    endfunction

    // One shift-and-add step on the {hi, lo} product pair; lo starts as the multiplier.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                    input logic [WIDTH-1:0] lo,
                                                    input logic [WIDTH-1:0] mc);
        logic [WIDTH:0] sum;
        sum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
        mul_step = {sum, lo[WIDTH-1:1]};
    endfunction

    // Operand B selection, adder/subtractor and comparison terms.
    always_comb begin
        if (imm_sel == 1'b0) begin
            b_s = rsrc;
        end else if ((opcode == OP_ADDU) || (opcode == OP_ADDCU)) begin
            b_s = WIDTH'(imm);
        end else begin
            b_s = WIDTH'($signed(imm));
        end
        cin_s       = ((opcode == OP_ADDC) || (opcode == OP_ADDCU)) ? flags_r[FC] : 1'b0;
        add_s       = {1'b0, rdest} + {1'b0, b_s} + {{WIDTH{1'b0}}, cin_s};
        sub_s       = {1'b0, rdest} - {1'b0, b_s};
        add_ovf_s   = (rdest[WIDTH-1] == b_s[WIDTH-1]) && (add_s[WIDTH-1] != rdest[WIDTH-1]);
        sub_ovf_s   = (rdest[WIDTH-1] != b_s[WIDTH-1]) && (sub_s[WIDTH-1] != rdest[WIDTH-1]);
        lt_s        = (rdest < b_s);
        slt_s       = ($signed(rdest) < $signed(b_s));
        n_s         = b_s[SHW-1:0];
        sh_first_s  = shift_one(opcode, rdest);
        sh_next_s   = shift_one(op_r, acc_r);
        mul_first_s = mul_step({WIDTH{1'b0}}, b_s, rdest);
        mul_next_s  = mul_step(acc_r, lo_r, mcand_r);
        case (opcode)
            OP_AND:  logic_res_s = rdest & b_s;
            OP_OR:   logic_res_s = rdest | b_s;
            OP_XOR:  logic_res_s = rdest ^ b_s;
            default: logic_res_s = ~rdest;
        endcase
    end

    // Next-state and datapath updates; the first shift/multiply step runs on the start edge.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        acc_s    = acc_r;
        lo_s     = lo_r;
        mcand_s  = mcand_r;
        op_s     = op_r;
        result_s = result_r;
        flags_s  = flags_r;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (opcode)
                        OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU: begin
                            result_s    = add_s[WIDTH-1:0];
                            flags_s[FC] = add_s[WIDTH];
                            if ((opcode == OP_ADD) || (opcode == OP_ADDC)) begin
                                flags_s[FF] = add_ovf_s;
                            end else begin
                                flags_s[FF] = flags_r[FF];
                            end
                            done_s = 1'b1;
                        end
                        OP_SUB, OP_CMP: begin
                            flags_s[FL] = lt_s;
                            flags_s[FN] = slt_s;
                            flags_s[FZ] = (rdest == b_s);
                            if (opcode == OP_SUB) begin
                                result_s    = sub_s[WIDTH-1:0];
                                flags_s[FC] = sub_s[WIDTH];
                                flags_s[FF] = sub_ovf_s;
                            end else begin
                                result_s = result_r;
                            end
                            done_s = 1'b1;
                        end
                        OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                            result_s    = logic_res_s;
                            flags_s[FZ] = (logic_res_s == {WIDTH{1'b0}});
                            done_s      = 1'b1;
                        end
                        OP_LSH, OP_RSH, OP_ARSH: begin
                            if (n_s == {SHW{1'b0}}) begin
                                result_s    = rdest;
                                flags_s[FZ] = (rdest == {WIDTH{1'b0}});
                                done_s      = 1'b1;
                            end else if (n_s == SHW'(1)) begin
                                result_s    = sh_first_s;
                                flags_s[FZ] = (sh_first_s == {WIDTH{1'b0}});
                                done_s      = 1'b1;
                            end else begin
                                state_s = ST_SHIFT;
                                acc_s   = sh_first_s;
                                cnt_s   = CW'(n_s) - CW'(1);
                                op_s    = opcode;
                            end
                        end
                        OP_MUL: begin
                            state_s = ST_MUL;
                            acc_s   = mul_first_s[2*WIDTH-1:WIDTH];
                            lo_s    = mul_first_s[WIDTH-1:0];
                            mcand_s = rdest;
                            cnt_s   = CW'(WIDTH - 1);
                        end
                        default: begin
                            done_s = 1'b1;
                        end
                    endcase
                end else begin
                    done_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                acc_s = sh_next_s;
                cnt_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_s     = ST_IDLE;
                    result_s    = sh_next_s;
                    flags_s[FZ] = (sh_next_s == {WIDTH{1'b0}});
                    done_s      = 1'b1;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_MUL: begin
                acc_s = mul_next_s[2*WIDTH-1:WIDTH];
                lo_s  = mul_next_s[WIDTH-1:0];
                cnt_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_s     = ST_IDLE;
                    result_s    = mul_next_s[WIDTH-1:0];
                    flags_s[FF] = |mul_next_s[2*WIDTH-1:WIDTH];
                    done_s      = 1'b1;
                end else begin
                    state_s = ST_MUL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            op_r     <= 5'b00000;
            result_r <= {WIDTH{1'b0}};
            flags_r  <= 5'b00000;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            acc_r    <= acc_s;
            lo_r     <= lo_s;
            mcand_r  <= mcand_s;
            op_r     <= op_s;
            result_r <= result_s;
            flags_r  <= flags_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
        end
    end

    assign result = result_r;
    assign flags  = flags_r;
    assign done   = done_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=16); flags are {C,L,F,Z,N}.
module tb_seq_alu;
    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    localparam logic [4:0] ADD   = 5'b00000;
    localparam logic [4:0] ADDU  = 5'b00010;
    localparam logic [4:0] ADDC  = 5'b00100;
    localparam logic [4:0] SUB   = 5'b01000;
    localparam logic [4:0] CMP   = 5'b01010;
    localparam logic [4:0] AND_  = 5'b01101;
    localparam logic [4:0] OR_   = 5'b01110;
    localparam logic [4:0] XOR_  = 5'b01111;
    localparam logic [4:0] NOT_  = 5'b10000;
    localparam logic [4:0] LSH   = 5'b10001;
    localparam logic [4:0] RSH   = 5'b10011;
    localparam logic [4:0] ARSH  = 5'b10110;
    localparam logic [4:0] NOP   = 5'b10111;
    localparam logic [4:0] MUL   = 5'b11000;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [4:0]       opcode;
    logic             imm_sel;
    logic [WIDTH-1:0] rdest;
    logic [WIDTH-1:0] rsrc;
    logic [7:0]       imm;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic [4:0]       flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .imm_sel(imm_sel),
        .rdest(rdest), .rsrc(rsrc), .imm(imm),
        .result(result), .busy(busy), .done(done), .flags(flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] r, input logic [4:0] f,
                             input logic b, input logic d);
        check({tag, ".result"}, 32'(result), 32'(r));
        check({tag, ".flags"},  32'(flags),  32'(f));
        check({tag, ".busy"},   32'(busy),   32'(b));
        check({tag, ".done"},   32'(done),   32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; returns 1 time unit after that edge.
    task automatic issue(input logic [4:0] opc, input logic [15:0] a, input logic [15:0] b,
                         input logic isel, input logic [7:0] iv);
        opcode  = opc;
        rdest   = a;
        rsrc    = b;
        imm_sel = isel;
        imm     = iv;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b1;
        opcode  = ADD;
        rdest   = 16'h0001;
        rsrc    = 16'h0001;
        imm_sel = 1'b0;
        imm     = 8'h00;
        tick();
        tick();
        check_all("reset", 16'h0000, 5'b00000, 1'b0, 1'b0);

        reset = 1'b0;
        issue(ADD, 16'h7FFF, 16'h0001, 1'b0, 8'h00);
        check_all("add_ovf", 16'h8000, 5'b00100, 1'b0, 1'b1);
        issue(ADDU, 16'hFFFF, 16'h0001, 1'b0, 8'h00);
        check_all("addu_carry", 16'h0000, 5'b10100, 1'b0, 1'b1);
        issue(ADDC, 16'h0000, 16'h0000, 1'b0, 8'h00);
        check_all("addc_cin", 16'h0001, 5'b00000, 1'b0, 1'b1);
        tick();
        check("done_single_pulse", 32'(done), 32'd0);

        issue(CMP, 16'hFFFF, 16'h0001, 1'b0, 8'h00);
        check_all("cmp", 16'h0001, 5'b00001, 1'b0, 1'b1);
        issue(SUB, 16'h0003, 16'h0005, 1'b0, 8'h00);
        check_all("sub_borrow", 16'hFFFE, 5'b11001, 1'b0, 1'b1);
        issue(SUB, 16'h8000, 16'h0001, 1'b0, 8'h00);
        check_all("sub_ovf", 16'h7FFF, 5'b00101, 1'b0, 1'b1);
        issue(AND_, 16'h00F0, 16'hFFFF, 1'b1, 8'h0F);
        check_all("and_imm_zero", 16'h0000, 5'b00111, 1'b0, 1'b1);
        issue(XOR_, 16'h1234, 16'h0000, 1'b1, 8'h80);
        check_all("xor_imm_sext", 16'hEDB4, 5'b00101, 1'b0, 1'b1);
        issue(ADDU, 16'h0001, 16'h0000, 1'b1, 8'h80);
        check_all("addu_imm_zext", 16'h0081, 5'b00101, 1'b0, 1'b1);
        issue(ADD, 16'h0100, 16'h0000, 1'b1, 8'h80);
        check_all("add_imm_sext", 16'h0080, 5'b10001, 1'b0, 1'b1);
        issue(NOT_, 16'hFFFF, 16'h0000, 1'b0, 8'h00);
        check_all("not", 16'h0000, 5'b10011, 1'b0, 1'b1);
        issue(OR_, 16'h0F00, 16'h00F0, 1'b0, 8'h00);
        check_all("or", 16'h0FF0, 5'b10001, 1'b0, 1'b1);
        issue(NOP, 16'hAAAA, 16'h5555, 1'b0, 8'h00);
        check_all("nop", 16'h0FF0, 5'b10001, 1'b0, 1'b1);
        issue(5'b00001, 16'hAAAA, 16'h5555, 1'b0, 8'h00);
        check_all("undef_op", 16'h0FF0, 5'b10001, 1'b0, 1'b1);

        // ARSH by 4 with a competing request held across cycles 1 and 2.
        issue(ARSH, 16'h8000, 16'h0004, 1'b0, 8'h00);
        check_all("arsh_c1", 16'h0FF0, 5'b10001, 1'b1, 1'b0);
        opcode = ADD;
        rdest  = 16'h0001;
        rsrc   = 16'h0001;
        start  = 1'b1;
        tick();
        check_all("arsh_c2", 16'h0FF0, 5'b10001, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        check_all("arsh_c3", 16'h0FF0, 5'b10001, 1'b1, 1'b0);
        tick();
        check_all("arsh_done", 16'hF800, 5'b10001, 1'b0, 1'b1);
        tick();
        check_all("arsh_after", 16'hF800, 5'b10001, 1'b0, 1'b0);

        issue(LSH, 16'h1234, 16'h0000, 1'b0, 8'h00);
        check_all("lsh_n0", 16'h1234, 5'b10001, 1'b0, 1'b1);
        issue(LSH, 16'h8001, 16'h0001, 1'b0, 8'h00);
        check_all("lsh_n1", 16'h0002, 5'b10001, 1'b0, 1'b1);
        issue(RSH, 16'h0004, 16'h0000, 1'b1, 8'h03);
        check_all("rsh_c1", 16'h0002, 5'b10001, 1'b1, 1'b0);
        tick();
        check_all("rsh_c2", 16'h0002, 5'b10001, 1'b1, 1'b0);
        tick();
        check_all("rsh_done", 16'h0000, 5'b10011, 1'b0, 1'b1);

        issue(MUL, 16'h0003, 16'h0005, 1'b0, 8'h00);
        for (int i = 1; i < 16; i++) begin
            check("mul35_wait_done", 32'(done), 32'd0);
            tick();
        end
        check_all("mul35", 16'h000F, 5'b10011, 1'b0, 1'b1);

        issue(MUL, 16'h0100, 16'h0100, 1'b0, 8'h00);
        for (int i = 1; i < 16; i++) begin
            check("mul_busy", 32'(busy), 32'd1);
            check("mul_hidden", 32'(result), 32'h000F);
            tick();
        end
        check_all("mul_hi", 16'h0000, 5'b10111, 1'b0, 1'b1);

        // Second multiply aborted by reset sampled on the eighth edge after start.
        issue(MUL, 16'h0100, 16'h0100, 1'b0, 8'h00);
        for (int i = 1; i < 8; i++) begin
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all("mul_abort", 16'h0000, 5'b00000, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        issue(ADD, 16'h0002, 16'h0003, 1'b0, 8'h00);
        check_all("add_after_abort", 16'h0005, 5'b00000, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
